// File: rtl/slave_ahb_mem.sv
// AHB-Lite word-addressed memory slave with programmable wait states,
// ERROR responses for illegal transfers, and pipelined back-to-back beats.
module slave_ahb_mem #(
  parameter int unsigned MEM_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK_SLAVE,
  input  logic        RESET_SLAVE,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic [1:0]  wait_cfg,
  output logic        HREADY,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int          IDX_W = $clog2(MEM_DEPTH);
  localparam logic [31:0] SPAN  = 32'(MEM_DEPTH * 4);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t            state, state_nxt;
  logic [1:0]        wait_cnt, wait_cnt_nxt;
  logic [31:0]       haddr_p1;
  logic              hwrite_p1;
  logic [2:0]        hsize_p1;
  logic [31:0]       mem [MEM_DEPTH];
  logic [31:0]       offs_p1;
  logic [IDX_W-1:0]  mem_idx;
  logic              hready_fsm;
  logic              hresp_fsm;
  logic [31:0]       rd_data;
  logic              mem_we;
  logic              accept;
  logic              unused_ok;

  // Offset-based check: addresses below BASE_ADDR wrap to huge offsets and fail.
  function automatic logic xfer_legal(input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] offs;
    offs = addr - BASE_ADDR;
    return (offs < SPAN) && (addr[1:0] == 2'b00) && (size == 3'b010);
  endfunction

  assign offs_p1 = haddr_p1 - BASE_ADDR;
  assign mem_idx = offs_p1[IDX_W+1:2];

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    hready_fsm   = 1'b1;
    hresp_fsm    = 1'b0;
    rd_data      = 32'h0;
    mem_we       = 1'b0;
    case (state)
      S_IDLE: ;
      S_WAIT: begin
        hready_fsm   = 1'b0;
        wait_cnt_nxt = wait_cnt - 2'd1;
        if (wait_cnt <= 2'd1) state_nxt = S_DATA;
      end
      S_DATA: begin
        mem_we = hwrite_p1;
        if (!hwrite_p1) rd_data = mem[mem_idx];
      end
      S_ERR1: begin
        hready_fsm = 1'b0;
        hresp_fsm  = 1'b1;
        state_nxt  = S_ERR2;
      end
      S_ERR2: hresp_fsm = 1'b1;
      default: state_nxt = S_IDLE;
    endcase

    // Every HREADY=1 state can take a new address phase (pipelined beats).
    accept = hready_fsm && HSEL && HTRANS[1];
    if (hready_fsm) begin
      if (!accept) begin
        state_nxt = S_IDLE;
      end else if (!xfer_legal(HADDR, HSIZE)) begin
        state_nxt    = S_ERR1;
        wait_cnt_nxt = 2'd0;
      end else begin
        state_nxt    = (wait_cfg != 2'd0) ? S_WAIT : S_DATA;
        wait_cnt_nxt = wait_cfg;
      end
    end
  end

  always_ff @(posedge CLK_SLAVE) begin
    if (RESET_SLAVE) begin
      state     <= S_IDLE;
      wait_cnt  <= 2'd0;
      haddr_p1  <= 32'h0;
      hwrite_p1 <= 1'b0;
      hsize_p1  <= 3'b000;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept) begin
        haddr_p1  <= HADDR;
        hwrite_p1 <= HWRITE;
        hsize_p1  <= HSIZE;
      end
    end
  end

  // Reset has priority, so a write whose data phase is cut short never lands.
  always_ff @(posedge CLK_SLAVE) begin
    if (RESET_SLAVE) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] <= 32'h0;
    end else if (mem_we) begin
      mem[mem_idx] <= HWDATA;
    end
  end

  assign HREADY = RESET_SLAVE ? 1'b1  : hready_fsm;
  assign HRESP  = RESET_SLAVE ? 1'b0  : hresp_fsm;
  assign HRDATA = RESET_SLAVE ? 32'h0 : rd_data;

  assign unused_ok = ^{HBURST, HTRANS[0], hsize_p1, offs_p1[31:IDX_W+2], offs_p1[1:0]};

endmodule

// File: tb/tb_slave_ahb_mem.sv
// Scoreboard bench for slave_ahb_mem: a pipelined AHB master drives directed
// beats and pushes expectations; a monitor pops them on each completed data phase.
module tb_slave_ahb_mem;

  localparam logic [1:0] ID = 2'b00, BZ = 2'b01, NS = 2'b10, SQ = 2'b11;

  logic        CLK_SLAVE = 1'b0;
  logic        RESET_SLAVE;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic [1:0]  wait_cfg;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;

  slave_ahb_mem #(.MEM_DEPTH(16), .BASE_ADDR(32'h0000_0000)) dut (
    .CLK_SLAVE(CLK_SLAVE), .RESET_SLAVE(RESET_SLAVE), .HSEL(HSEL), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .wait_cfg(wait_cfg), .HREADY(HREADY), .HRESP(HRESP),
    .HRDATA(HRDATA)
  );

  always #5 CLK_SLAVE = ~CLK_SLAVE;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        is_wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [1:0]  wc;
    logic        err;
    logic [31:0] rdata;
  } beat_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  beat_t beats[$];
  exp_t  sb[$];
  int    n_vec = 0;
  int    n_bad = 0;
  logic  dp_active = 1'b0;
  int    wcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one data phase in flight at most; expectations popped on its completion.
  always @(negedge CLK_SLAVE) begin
    exp_t e;
    if (RESET_SLAVE === 1'b1) begin
      chk("rst_hready", 32'(HREADY), 32'd1);
      chk("rst_hresp",  32'(HRESP),  32'd0);
      chk("rst_hrdata", HRDATA,      32'h0);
      if (dp_active && sb.size() > 0) void'(sb.pop_front());
      dp_active = 1'b0;
      wcnt      = 0;
    end else begin
      if (dp_active) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL sb_empty: data phase with no expectation (t=%0t)", $time);
          dp_active = 1'b0;
        end else if (!HREADY) begin
          chk("wait_hresp",  32'(HRESP), 32'(sb[0].err));
          chk("wait_hrdata", HRDATA,     32'h0);
          wcnt++;
        end else begin
          e = sb.pop_front();
          chk("dp_hresp",  32'(HRESP), 32'(e.err));
          chk("dp_hrdata", HRDATA,     e.rdata);
          chk("dp_waits",  32'(wcnt),  32'(e.waits));
          wcnt = 0;
        end
      end else begin
        chk("idle_hready", 32'(HREADY), 32'd1);
        chk("idle_hresp",  32'(HRESP),  32'd0);
        chk("idle_hrdata", HRDATA,      32'h0);
      end
      if (HREADY) dp_active = HSEL && HTRANS[1];
    end
  end

  task automatic present(input beat_t b);
    HSEL     = b.sel;
    HTRANS   = b.trans;
    HADDR    = b.addr;
    HWRITE   = b.is_wr;
    HSIZE    = b.size;
    wait_cfg = b.wc;
    HBURST   = 3'b001;
    if (b.sel && b.trans[1])
      sb.push_back('{err: b.err, rdata: b.rdata, waits: (b.err ? 1 : int'(b.wc))});
  endtask

  task automatic wr(input logic [1:0] tr, input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] wc, input logic err = 1'b0, input logic [2:0] sz = 3'b010);
    beats.push_back('{sel: 1'b1, trans: tr, addr: a, is_wr: 1'b1, size: sz, wdata: d,
                      wc: wc, err: err, rdata: 32'h0});
  endtask

  task automatic rd(input logic [1:0] tr, input logic [31:0] a, input logic [31:0] exp_d,
                    input logic [1:0] wc, input logic err = 1'b0, input logic [2:0] sz = 3'b010);
    beats.push_back('{sel: 1'b1, trans: tr, addr: a, is_wr: 1'b0, size: sz, wdata: 32'h0,
                      wc: wc, err: err, rdata: exp_d});
  endtask

  task automatic nx(input logic sel, input logic [1:0] tr, input logic [31:0] a, input logic [31:0] d);
    beats.push_back('{sel: sel, trans: tr, addr: a, is_wr: 1'b1, size: 3'b010, wdata: d,
                      wc: 2'd0, err: 1'b0, rdata: 32'h0});
  endtask

  // Pipelined master: next address is presented as soon as the previous one is taken.
  task automatic run_beats();
    int   k = 0;
    int   guard = 0;
    logic rdy;
    nx(1'b0, ID, 32'h0, 32'h0);
    present(beats[0]);
    while (k < beats.size()) begin
      @(negedge CLK_SLAVE);
      rdy = HREADY;
      @(posedge CLK_SLAVE);
      #1;
      guard++;
      if (guard > 200) begin
        n_vec++;
        n_bad++;
        $display("FAIL timeout: beat %0d never accepted", k);
        break;
      end
      if (rdy) begin
        HWDATA = beats[k].wdata;
        k++;
        if (k < beats.size()) present(beats[k]);
      end
    end
    beats.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_SLAVE = 1'b1;
    HSEL = 1'b0; HADDR = 32'h0; HWRITE = 1'b0; HSIZE = 3'b010; HBURST = 3'b000;
    HTRANS = ID; HWDATA = 32'h0; wait_cfg = 2'd0;
    repeat (2) @(posedge CLK_SLAVE);
    #1 RESET_SLAVE = 1'b0;

    // Single write then read, no waits
    wr(NS, 32'h04, 32'hDEAD_BEEF, 2'd0);
    rd(NS, 32'h04, 32'hDEAD_BEEF, 2'd0);
    run_beats();

    // INCR4 write then INCR4 read with two wait states per beat
    wr(NS, 32'h10, 32'd1, 2'd2); wr(SQ, 32'h14, 32'd2, 2'd2);
    wr(SQ, 32'h18, 32'd3, 2'd2); wr(SQ, 32'h1C, 32'd4, 2'd2);
    rd(NS, 32'h10, 32'd1, 2'd2); rd(SQ, 32'h14, 32'd2, 2'd2);
    rd(SQ, 32'h18, 32'd3, 2'd2); rd(SQ, 32'h1C, 32'd4, 2'd2);
    run_beats();

    // Errors: out of range, misaligned, bad size, error ignores wait_cfg
    rd(NS, 32'h40, 32'h0, 2'd0, 1'b1);
    wr(NS, 32'h02, 32'hFFFF_FFFF, 2'd0, 1'b1);
    wr(NS, 32'h30, 32'h0000_0077, 2'd0, 1'b1, 3'b001);
    wr(NS, 32'h44, 32'h1111_1111, 2'd3, 1'b1);
    wr(NS, 32'h3C, 32'h3C3C_3C3C, 2'd0);
    rd(NS, 32'h3C, 32'h3C3C_3C3C, 2'd0);
    rd(NS, 32'h30, 32'h0, 2'd0);
    rd(NS, 32'h00, 32'h0, 2'd0);
    rd(NS, 32'h04, 32'hDEAD_BEEF, 2'd0);
    run_beats();

    // Write-to-read forwarding; wait_cfg changed during a data phase
    wr(NS, 32'h08, 32'hA5A5_A5A5, 2'd0);
    rd(NS, 32'h08, 32'hA5A5_A5A5, 2'd0);
    wr(NS, 32'h0C, 32'h1234_5678, 2'd3);
    rd(NS, 32'h0C, 32'h1234_5678, 2'd1);
    rd(NS, 32'h10, 32'd1, 2'd0);
    run_beats();

    // BUSY and deselected cycles inside a burst
    wr(NS, 32'h20, 32'h11, 2'd1);
    nx(1'b1, BZ, 32'h24, 32'hBAD0_0001);
    wr(SQ, 32'h24, 32'h22, 2'd1);
    nx(1'b0, NS, 32'h28, 32'hBAD0_0002);
    wr(SQ, 32'h2C, 32'h44, 2'd1);
    nx(1'b1, ID, 32'h30, 32'hBAD0_0003);
    rd(NS, 32'h20, 32'h11, 2'd1);
    rd(SQ, 32'h24, 32'h22, 2'd1);
    rd(SQ, 32'h28, 32'h0,  2'd1);
    rd(SQ, 32'h2C, 32'h44, 2'd1);
    run_beats();

    // Reset during the wait states of a write aborts it and clears memory
    wr(NS, 32'h0C, 32'hCAFE_F00D, 2'd3);
    present(beats[0]);
    beats.delete();
    @(posedge CLK_SLAVE);
    #1;
    HWDATA = 32'hCAFE_F00D; HSEL = 1'b0; HTRANS = ID; RESET_SLAVE = 1'b1;
    @(posedge CLK_SLAVE);
    #1 RESET_SLAVE = 1'b0;
    @(posedge CLK_SLAVE);
    #1;
    rd(NS, 32'h0C, 32'h0, 2'd0);
    rd(NS, 32'h04, 32'h0, 2'd0);
    rd(NS, 32'h3C, 32'h0, 2'd0);
    run_beats();

    repeat (2) @(posedge CLK_SLAVE);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/slave_ahb_mem.md
SLAVE_AHB_MEM -- requirements
Module: slave_ahb_mem

Interface
REQ-001 Parameter MEM_DEPTH, 16, number of 32-bit words in the memory array (power of two, 4..64).
REQ-002 Parameter BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to MEM_DEPTH*4.
REQ-003 CLK_SLAVE  in  1  single clock; all logic on rising edge.
REQ-004 RESET_SLAVE  in  1  reset, synchronous, active-high.
REQ-005 HSEL  in  1  slave select from the address decoder.
REQ-006 HADDR  in  32  transfer byte address (address phase).
REQ-007 HWRITE  in  1  1 = write, 0 = read (address phase).
REQ-008 HSIZE  in  3  transfer size; only 3'b010 (word) is legal.
REQ-009 HBURST  in  3  burst type; sampled, no functional effect.
REQ-010 HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-011 HWDATA  in  32  write data (data phase).
REQ-012 wait_cfg  in  2  wait states inserted before completing each OKAY transfer (0..3).
REQ-013 HREADY  out  1  1 = current data phase completes this cycle.
REQ-014 HRESP  out  1  0 = OKAY, 1 = ERROR.
REQ-015 HRDATA  out  32  read data, valid when HREADY=1, HRESP=0 and the data phase is a read.

Function
REQ-016 Address phase accepted only on a cycle with HSEL=1, HTRANS[1]=1 and HREADY=1; HADDR, HWRITE, HSIZE captured into registers on that edge.
REQ-017 IDLE/BUSY or HSEL=0 with HREADY=1: no transfer; next cycle HREADY=1, HRESP=0.
REQ-018 Transfer is ERROR if HADDR outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*4-1], HADDR[1:0]!=0, or HSIZE!=3'b010.
REQ-019 State machine states: S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2.
REQ-020 S_IDLE: HREADY=1, HRESP=0; on accepted legal transfer -> S_WAIT if wait_cfg!=0 else S_DATA; on accepted illegal transfer -> S_ERR1.
REQ-021 S_WAIT: HREADY=0, HRESP=0; wait counter loaded with wait_cfg (sampled at address phase) and decremented each cycle; -> S_DATA when counter reaches 1.
REQ-022 S_DATA: HREADY=1, HRESP=0; write stores HWDATA into mem[(addr-BASE_ADDR)>>2] at end of this cycle; read drives HRDATA from that word this cycle.
REQ-023 S_DATA with a new accepted transfer in the same cycle: pipelined, next state chosen as in REQ-020, no idle cycle between beats; otherwise -> S_IDLE.
REQ-024 S_ERR1: HREADY=0, HRESP=1; -> S_ERR2 unconditionally.
REQ-025 S_ERR2: HREADY=1, HRESP=1; an address phase presented here is accepted per REQ-016/020.
REQ-026 ERROR transfers never modify memory; HRDATA during error cycles is 32'h0.
REQ-027 Read whose address equals an immediately preceding write's address returns the newly written data (write-to-read forwarding, zero bubbles).
REQ-028 HRDATA is 32'h0 in every cycle that is not a completing read data phase.
REQ-029 Wait count uses the wait_cfg value captured at the address phase; wait_cfg changes during a data phase do not affect it.
REQ-030 Address index computed modulo MEM_DEPTH after range check; no wrap beyond the array.

Reset
REQ-031 RESET_SLAVE=1 at a rising edge: state -> S_IDLE, wait counter 0, captured address/control cleared, all memory words 32'h0.
REQ-032 Outputs in and after reset cycle: HREADY=1, HRESP=0, HRDATA=32'h0.
REQ-033 Reset mid-transfer (any state) aborts it; a pending write is not committed.

Verification
REQ-034 wait_cfg=0, NONSEQ write 32'hDEAD_BEEF to 0x04, then NONSEQ read 0x04 -> write data phase HREADY=1 immediately; read returns 32'hDEAD_BEEF, HRESP=0.
REQ-035 wait_cfg=2, INCR4 write 0x10..0x1C data 1..4 then INCR4 read -> each beat 2 cycles HREADY=0 then 1 cycle HREADY=1; reads return 1,2,3,4.
REQ-036 Read 0x40 (MEM_DEPTH=16) and write HADDR=0x02 -> each gives HREADY 0 then 1 with HRESP=1 both cycles; memory unchanged, HRDATA=0.
REQ-037 Back-to-back write 0x08=32'hA5A5_A5A5 followed directly by read 0x08 -> read returns 32'hA5A5_A5A5 with no extra wait cycle.
REQ-038 wait_cfg=3, assert RESET_SLAVE during S_WAIT of a write to 0x0C -> HREADY=1, HRESP=0 next cycle; later read of 0x0C returns 32'h0.
REQ-039 HTRANS=BUSY and HSEL=0 cycles interleaved in a burst -> HREADY stays 1, HRESP 0, memory untouched.
